shift_readback: RTL and testbench



---
 rtl/overlay_pkg.sv | 11 +
 rtl/shift_readback.sv | 109 ++++++++++
 tb/tb_shift_readback.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay shift-chain access blocks.
package overlay_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

endpackage

// File: rtl/shift_readback.sv
// Reads the overlay shift chain tail out LSB-first, packing bits into bytes
// handed to the UART transmitter over a valid/ready handshake.
module shift_readback
  import overlay_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          RECIRCULATE = 1'b1
) (
  input  logic              SCLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [CNT_W-1:0]  BIT_COUNT,
  output logic              BUSY,
  output logic              DONE,
  input  logic              SHIFT_TAIL,
  output logic              SHIFT_HEAD,
  output logic              SHIFT_ENABLE,
  input  logic              UART_READY,
  output logic              TX_VALID,
  output logic [BYTE_W-1:0] TX_DATA
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              shift_en_q, shift_en_d;
  logic              tx_valid_q, tx_valid_d;

  // Next-state and datapath; the chain only advances in SHIFT, so a pending byte stalls it.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (BIT_COUNT != '0) begin
            rem_d   = BIT_COUNT;
            idx_d   = '0;
            byte_d  = '0;
            state_d = ST_SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        byte_d[idx_q] = SHIFT_TAIL;
        rem_d         = rem_q - CNT_W'(1);
        idx_d         = idx_q + IDX_W'(1);
        if ((idx_q == IDX_W'(BYTE_W - 1)) || (rem_q == CNT_W'(1))) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (UART_READY) begin
          if (rem_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_d  = '0;
            idx_d   = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d != ST_IDLE);
    shift_en_d = (state_d == ST_SHIFT);
    tx_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge SCLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      shift_en_q <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      shift_en_q <= shift_en_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign SHIFT_ENABLE = shift_en_q;
  assign TX_VALID     = tx_valid_q;
  assign TX_DATA      = byte_q;
  // Feeding the tail back into the head makes a full-length readback non-destructive.
  assign SHIFT_HEAD   = (RECIRCULATE && shift_en_q) ? SHIFT_TAIL : 1'b0;

endmodule

// File: tb/tb_shift_readback.sv
// Directed scoreboard bench for shift_readback with behavioural shift-chain models.
module tb_shift_readback;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        start, start0;
  logic [15:0] bit_count;
  logic        ready;

  logic        busy, done, tail, head, en, valid;
  logic [7:0]  data;
  logic        busy0, done0, tail0, head0, en0, valid0;
  logic [7:0]  data0;

  logic [15:0] chain1 = '0, chain0 = '0;
  logic [3:0]  len1_m1 = 4'd15;
  logic        load1 = 1'b0, load0 = 1'b0;
  logic [15:0] load_val = '0;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int sh1 = 0, dn1 = 0, b1 = 0, sh0 = 0, b0 = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  always #5 sclk = ~sclk;

  shift_readback #(.CNT_W(16), .RECIRCULATE(1'b1)) dut (
    .SCLK(sclk), .RESET(rst_n), .START(start), .BIT_COUNT(bit_count),
    .BUSY(busy), .DONE(done), .SHIFT_TAIL(tail), .SHIFT_HEAD(head),
    .SHIFT_ENABLE(en), .UART_READY(ready), .TX_VALID(valid), .TX_DATA(data)
  );

  shift_readback #(.CNT_W(16), .RECIRCULATE(1'b0)) dut0 (
    .SCLK(sclk), .RESET(rst_n), .START(start0), .BIT_COUNT(bit_count),
    .BUSY(busy0), .DONE(done0), .SHIFT_TAIL(tail0), .SHIFT_HEAD(head0),
    .SHIFT_ENABLE(en0), .UART_READY(ready), .TX_VALID(valid0), .TX_DATA(data0)
  );

  assign tail  = chain1[0];
  assign tail0 = chain0[0];

  // Chain models: tail is bit 0, head enters at bit len-1.
  always @(posedge sclk) begin : chain_model
    logic [15:0] t;
    if (load1) begin
      chain1 <= load_val;
    end else if (en) begin
      t = chain1 >> 1;
      t[len1_m1] = head;
      chain1 <= t;
    end
    if (load0) begin
      chain0 <= load_val;
    end else if (en0) begin
      t = chain0 >> 1;
      t[15] = head0;
      chain0 <= t;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every accepted byte against the queue.
  always @(negedge sclk) begin
    if (en) sh1++;
    if (done) dn1++;
    if (en0) sh0++;
    if (valid && ready) begin
      b1++;
      if (q1.size() == 0) chk("byte_unexpected", 32'(q1.size()), 32'd1);
      else chk("tx_byte", 32'(data), 32'(q1.pop_front()));
    end
    if (valid0 && ready) begin
      b0++;
      if (q0.size() == 0) chk("byte0_unexpected", 32'(q0.size()), 32'd1);
      else chk("tx_byte0", 32'(data0), 32'(q0.pop_front()));
    end
  end

  task automatic load_chain(input logic [15:0] v, input logic [3:0] lm1);
    @(negedge sclk);
    load_val = v; len1_m1 = lm1; load1 = 1'b1;
    @(negedge sclk);
    load1 = 1'b0;
  endtask

  task automatic go(input logic [15:0] n);
    @(negedge sclk);
    bit_count = n; start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge sclk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int base_sh, base_b, base_d, c, n;
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; bit_count = '0; ready = 1'b1;
    repeat (2) @(negedge sclk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    rst_n = 1'b1;

    // 8 bits 1,0,1,1,0,0,0,1 out of the tail -> 0x8D
    load_chain(16'h008D, 4'd7);
    q1.push_back(8'h8D);
    base_sh = sh1; base_b = b1; base_d = dn1;
    go(16'd8);
    chk("t1_busy", 32'(busy), 1);
    c = 0;
    for (int i = 0; i < 8; i++) begin
      if (en) c++;
      @(negedge sclk);
    end
    chk("t1_en_run", 32'(c), 8);
    chk("t1_en_off", 32'(en), 0);
    chk("t1_valid", 32'(valid), 1);
    chk("t1_data", 32'(data), 32'h8D);
    @(negedge sclk);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_valid_off", 32'(valid), 0);
    @(negedge sclk);
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_shifts", 32'(sh1 - base_sh), 8);
    chk("t1_bytes", 32'(b1 - base_b), 1);
    chk("t1_dones", 32'(dn1 - base_d), 1);

    // 12-bit chain 0xABC -> 0xBC, 0x0A
    load_chain(16'h0ABC, 4'd11);
    q1.push_back(8'hBC); q1.push_back(8'h0A);
    base_sh = sh1; base_b = b1; base_d = dn1;
    go(16'd12);
    wait_idle(100);
    @(negedge sclk);
    chk("t2_shifts", 32'(sh1 - base_sh), 12);
    chk("t2_bytes", 32'(b1 - base_b), 2);
    chk("t2_dones", 32'(dn1 - base_d), 1);
    chk("t2_queue", 32'(q1.size()), 0);
    chk("t2_chain", 32'(chain1), 32'h0ABC);

    // Back-pressure on a recirculating 16-bit readback of 0x1234
    ready = 1'b0;
    load_chain(16'h1234, 4'd15);
    q1.push_back(8'h34); q1.push_back(8'h12);
    base_sh = sh1; base_b = b1;
    go(16'd16);
    n = 0;
    while (!valid && n < 50) begin
      @(negedge sclk);
      n++;
    end
    chk("t3_valid_seen", 32'(valid), 1);
    chk("t3_chain_mid", 32'(chain1), 32'h3412);
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_valid", 32'(valid), 1);
      chk("t3_hold_data", 32'(data), 32'h34);
      chk("t3_hold_en", 32'(en), 0);
      @(negedge sclk);
    end
    chk("t3_chain_hold", 32'(chain1), 32'h3412);
    chk("t3_shifts_hold", 32'(sh1 - base_sh), 8);
    ready = 1'b1;
    wait_idle(100);
    @(negedge sclk);
    chk("t4_chain_recirc", 32'(chain1), 32'h1234);
    chk("t4_bytes", 32'(b1 - base_b), 2);
    chk("t4_shifts", 32'(sh1 - base_sh), 16);

    // Destructive readback on the non-recirculating instance
    @(negedge sclk);
    load_val = 16'h1234; load0 = 1'b1;
    @(negedge sclk);
    load0 = 1'b0;
    q0.push_back(8'h34); q0.push_back(8'h12);
    base_sh = sh0; base_b = b0;
    bit_count = 16'd16; start0 = 1'b1;
    @(negedge sclk);
    start0 = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      @(negedge sclk);
      n++;
    end
    chk("t4b_idle", 32'(busy0), 0);
    @(negedge sclk);
    chk("t4b_chain_zero", 32'(chain0), 0);
    chk("t4b_bytes", 32'(b0 - base_b), 2);
    chk("t4b_shifts", 32'(sh0 - base_sh), 16);
    chk("t4b_queue", 32'(q0.size()), 0);

    // Zero-length request
    base_sh = sh1; base_b = b1;
    go(16'd0);
    chk("t5_done", 32'(done), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_en", 32'(en), 0);
    chk("t5_valid", 32'(valid), 0);
    @(negedge sclk);
    chk("t5_done_pulse", 32'(done), 0);
    chk("t5_busy2", 32'(busy), 0);
    chk("t5_shifts", 32'(sh1 - base_sh), 0);
    chk("t5_bytes", 32'(b1 - base_b), 0);

    // Reset after three shifts of a 16-bit readback
    load_chain(16'h1234, 4'd15);
    base_sh = sh1; base_b = b1;
    go(16'd16);
    n = 0;
    while ((sh1 - base_sh) < 3 && n < 20) begin
      @(negedge sclk);
      n++;
    end
    chk("t6_shifting", 32'(en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_en", 32'(en), 0);
    chk("t6_valid", 32'(valid), 0);
    chk("t6_data", 32'(data), 0);
    chk("t6_head", 32'(head), 0);
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_en", 32'(en), 0);
    chk("t6_no_bytes", 32'(b1 - base_b), 0);

    // START while busy is ignored
    load_chain(16'hBEEF, 4'd15);
    q1.push_back(8'hEF); q1.push_back(8'hBE);
    base_sh = sh1; base_b = b1; base_d = dn1;
    go(16'd16);
    repeat (3) @(negedge sclk);
    bit_count = 16'd8; start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    wait_idle(100);
    repeat (3) @(negedge sclk);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_bytes", 32'(b1 - base_b), 2);
    chk("t7_shifts", 32'(sh1 - base_sh), 16);
    chk("t7_dones", 32'(dn1 - base_d), 1);
    chk("t7_queue", 32'(q1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
